// File: rtl/cntr8_ctrl.sv
// Control stage of the 8-bit counter: state register, next-state logic and
// value register, closing the loop through the external os_logic datapath.
module cntr8_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             load,
  input  logic             inc,
  input  logic [WIDTH-1:0] d_in,
  input  logic [WIDTH-1:0] os_d_out,
  output logic [2:0]       o_state,
  output logic [WIDTH-1:0] o_val
);

  typedef enum logic [2:0] {
    IDLE = 3'b000,
    LOAD = 3'b001,
    INC  = 3'b010,
    INC2 = 3'b011,
    DEC  = 3'b100,
    DEC2 = 3'b101
  } state_t;

  // Held as a plain vector so unused codes 110/111 are representable and recoverable.
  logic [2:0] state;
  logic [2:0] next_state;

  always_comb begin
    next_state = IDLE;
    if (state == 3'b110 || state == 3'b111) begin
      next_state = IDLE;
    end else if (!en) begin
      next_state = IDLE;
    end else if (load) begin
      next_state = LOAD;
    end else if (inc) begin
      next_state = (state == INC) ? INC2 : INC;
    end else begin
      next_state = (state == DEC) ? DEC2 : DEC;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      o_val <= '0;
    end else begin
      state <= next_state;
      // IDLE result is never captured, and the first step out of IDLE starts from the held value.
      if (next_state == LOAD) begin
        o_val <= d_in;
      end else if (next_state != IDLE && state != IDLE) begin
        o_val <= os_d_out;
      end
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_cntr8_ctrl.sv
// Directed bench for cntr8_ctrl with an inline os_logic model on the feedback path.
module tb_cntr8_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en;
  logic       load;
  logic       inc;
  logic [7:0] d_in;
  logic [7:0] os_d_out;
  logic [2:0] o_state;
  logic [7:0] o_val;

  int unsigned compared   = 0;
  int unsigned mismatched = 0;

  logic [10:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  cntr8_ctrl #(.WIDTH(8)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
    .load     (load),
    .inc      (inc),
    .d_in     (d_in),
    .os_d_out (os_d_out),
    .o_state  (o_state),
    .o_val    (o_val)
  );

  // os_logic: combinational result selected by the state code.
  always_comb begin
    os_d_out = 8'h00;
    case (o_state)
      3'b001:  os_d_out = o_val;
      3'b010:  os_d_out = o_val + 8'd1;
      3'b011:  os_d_out = o_val + 8'd2;
      3'b100:  os_d_out = o_val - 8'd1;
      3'b101:  os_d_out = o_val - 8'd2;
      default: os_d_out = 8'h00;
    endcase
  end

  task automatic check(input string tag, input logic [2:0] st, input logic [7:0] val);
    compared++;
    assert ({o_state, o_val} === {st, val}) else begin
      mismatched++;
      $error("FAIL %s: got state=%b val=%h, expected state=%b val=%h",
             tag, o_state, o_val, st, val);
    end
  endtask

  task automatic drive(input logic e, input logic l, input logic i, input logic [7:0] d,
                       input string tag, input logic [2:0] st, input logic [7:0] val);
    en = e; load = l; inc = i; d_in = d;
    exp_q.push_back({st, val});
    tag_q.push_back(tag);
  endtask

  task automatic sample();
    logic [10:0] e;
    string       t;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      compared++;
      mismatched++;
      $error("FAIL scoreboard_empty: got nothing queued, expected one entry");
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, e[10:8], e[7:0]);
    end
  endtask

  task automatic step(input logic e, input logic l, input logic i, input logic [7:0] d,
                      input string tag, input logic [2:0] st, input logic [7:0] val);
    @(negedge clk);
    drive(e, l, i, d, tag, st, val);
    sample();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; en = 1'b0; load = 1'b0; inc = 1'b0; d_in = 8'h00;
    #12;
    check("reset_init", 3'b000, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;

    // Reach INC2 with value 0x37, then reset asynchronously between edges.
    step(1, 1, 0, 8'h36, "pre_load", 3'b001, 8'h36);
    step(1, 0, 1, 8'h00, "pre_inc",  3'b010, 8'h36);
    step(1, 0, 1, 8'h00, "pre_inc2", 3'b011, 8'h37);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_now", 3'b000, 8'h00);
    @(posedge clk);
    #1;
    check("async_reset_held", 3'b000, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;

    step(1, 1, 0, 8'hFE, "load_fe", 3'b001, 8'hFE);
    step(1, 0, 1, 8'h00, "inc_1",   3'b010, 8'hFE);
    step(1, 0, 1, 8'h00, "inc2_1",  3'b011, 8'hFF);
    step(1, 0, 1, 8'h00, "inc_2",   3'b010, 8'h01);
    step(1, 0, 1, 8'h00, "inc2_2",  3'b011, 8'h02);

    step(1, 0, 0, 8'h00, "dec_1",   3'b100, 8'h04);
    step(1, 0, 0, 8'h00, "dec2_1",  3'b101, 8'h03);
    step(1, 0, 0, 8'h00, "dec_2",   3'b100, 8'h01);

    step(0, 1, 0, 8'h55, "en_wins",   3'b000, 8'h01);
    step(1, 0, 1, 8'h00, "idle_inc",  3'b010, 8'h01);
    step(1, 0, 1, 8'h00, "idle_inc2", 3'b011, 8'h02);

    step(1, 1, 0, 8'h10, "reload_a", 3'b001, 8'h10);
    step(1, 1, 0, 8'h20, "reload_b", 3'b001, 8'h20);

    step(1, 1, 0, 8'h01, "load_01",  3'b001, 8'h01);
    step(1, 0, 0, 8'h00, "dwrap_d",  3'b100, 8'h01);
    step(1, 0, 0, 8'h00, "dwrap_d2", 3'b101, 8'h00);
    step(1, 0, 0, 8'h00, "dwrap_d3", 3'b100, 8'hFE);
    step(1, 0, 1, 8'h00, "dir_up",   3'b010, 8'hFD);

    // Deposit an unused state code; the next edge must return to IDLE and hold the value.
    @(negedge clk);
    force dut.state = 3'b110;
    #1;
    release dut.state;
    drive(1, 0, 1, 8'h00, "illegal_state", 3'b000, 8'hFD);
    sample();
    step(1, 0, 1, 8'h00, "after_illegal", 3'b010, 8'hFD);

    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $error("FAIL scoreboard_leftover: got %0d entries, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
